// File: rtl/cic_comp_pkg.sv
// Shared constants for cic_comp_fir: tap counts, coefficient format, the 11 unique
// compensation coefficients (Q1.17, DC gain ~1.10) and the sequencer state encoding.
package cic_comp_pkg;

   localparam int TAPS      = 21;
   localparam int NUM_MAC   = 11;
   localparam int COEF_FRAC = 17;
   localparam int COEF_BITS = 18;

   typedef logic signed [COEF_BITS-1:0] coef_t;

   // h[0..9] pair with h[20..11]; h[10] is the centre tap
   localparam coef_t COEF [NUM_MAC] = '{
      -18'sd150,  18'sd260,   18'sd410,  -18'sd620,  -18'sd980,
       18'sd1460, 18'sd2350, -18'sd3600, -18'sd7800,  18'sd18400,
       18'sd125000
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/cic_comp_mac.sv
// Shared pre-adder, multiplier and wide accumulator for the symmetric compensation FIR.
// clr zeroes the accumulator for a new output; en adds (op_a + op_b) * coef.
module cic_comp_mac
   import cic_comp_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int COEF_WIDTH = 18,
   parameter int ACC_WIDTH  = DATA_WIDTH + 1 + COEF_WIDTH + 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] op_a_i,
   input  logic signed [DATA_WIDTH-1:0] op_b_i,
   input  logic signed [COEF_WIDTH-1:0] coef_i,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   localparam int PRE_W  = DATA_WIDTH + 1;
   localparam int PROD_W = PRE_W + COEF_WIDTH;

   logic signed [PRE_W-1:0]     pre;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

   always_comb begin
      pre   = PRE_W'(op_a_i) + PRE_W'(op_b_i);
      prod  = PROD_W'(pre) * PROD_W'(coef_i);
      acc_d = acc_q + ACC_WIDTH'(prod);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: decimate-by-2, 21-tap symmetric CIC droop compensator on one shared MAC.
// Define CIC_COMP_SAT_EN to saturate the output; otherwise it wraps to OUT_WIDTH bits.
module cic_comp_fir
   import cic_comp_pkg::*;
#(
   parameter int IN_WIDTH   = 38,
   parameter int SHIFT      = 20,
   parameter int DATA_WIDTH = 18,
   parameter int COEF_WIDTH = 18,
   parameter int OUT_WIDTH  = 18
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        nd,
   input  logic signed [IN_WIDTH-1:0]  din,
   output logic                        rdy,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        ovf
);

   localparam int ACC_WIDTH = DATA_WIDTH + 1 + COEF_WIDTH + 4;
   localparam int Y_WIDTH   = ACC_WIDTH - COEF_FRAC;

   typedef logic signed [DATA_WIDTH-1:0] sample_t;

   sample_t                      d_q [TAPS];
   sample_t                      x;
   state_t                       state_q;
   logic [3:0]                   k_q;
   logic                         phase_q, rdy_q, ovf_q;
   logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
   logic                         accept, compute, mac_en;
   logic [4:0]                   idx_lo, idx_hi;
   sample_t                      op_a, op_b;
   logic signed [COEF_WIDTH-1:0] coef;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic                         unused_bits;

   function automatic logic signed [OUT_WIDTH-1:0] reduce_y(input logic signed [Y_WIDTH-1:0] y);
`ifdef CIC_COMP_SAT_EN
      if (y[Y_WIDTH-1:OUT_WIDTH-1] != {(Y_WIDTH-OUT_WIDTH+1){y[Y_WIDTH-1]}}) begin
         reduce_y = y[Y_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else begin
         reduce_y = y[OUT_WIDTH-1:0];
      end
`else
      reduce_y = y[OUT_WIDTH-1:0];
`endif
   endfunction

   always_comb begin
      x       = din[SHIFT+DATA_WIDTH-1:SHIFT];
      accept  = nd && (state_q == IDLE || state_q == OUT);
      compute = accept && phase_q;
      mac_en  = (state_q == MAC);
      // step k folds tap k with its mirror 20-k; the centre tap has no partner
      idx_lo  = 5'(k_q);
      idx_hi  = 5'(TAPS - 1) - idx_lo;
      op_a    = d_q[idx_lo];
      op_b    = (k_q == 4'(NUM_MAC - 1)) ? '0 : d_q[idx_hi];
      coef    = COEF_WIDTH'(COEF[k_q]);
      dout_d  = reduce_y(acc[ACC_WIDTH-1:COEF_FRAC]);
   end

   cic_comp_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (compute),
      .en     (mac_en),
      .op_a_i (op_a),
      .op_b_i (op_b),
      .coef_i (coef),
      .acc    (acc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         phase_q <= 1'b0;
         rdy_q   <= 1'b0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < TAPS; i++) d_q[i] <= '0;
      end else begin
         rdy_q <= 1'b0;
         if (accept) begin
            d_q[0] <= x;
            for (int i = 1; i < TAPS; i++) d_q[i] <= d_q[i-1];
            phase_q <= ~phase_q;
         end
         // delay line is frozen while MAC reads it, so a sample arriving now is lost
         if (nd && state_q == MAC) ovf_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (compute) begin
                  state_q <= MAC;
                  k_q     <= '0;
               end
            end
            MAC: begin
               if (k_q == 4'(NUM_MAC - 1)) state_q <= OUT;
               else                        k_q     <= k_q + 4'd1;
            end
            OUT: begin
               rdy_q  <= 1'b1;
               dout_q <= dout_d;
               if (compute) begin
                  state_q <= MAC;
                  k_q     <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign unused_bits = ^{din[SHIFT-1:0], acc[COEF_FRAC-1:0]};

   assign rdy  = rdy_q;
   assign dout = dout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: a full 21-tap convolution reference feeds a scoreboard
// that is drained whenever the DUT pulses rdy (value and latency are both compared).
module tb_cic_comp_fir;

   localparam int IN_W  = 38;
   localparam int OUT_W = 18;

   logic                    clk;
   logic                    rst;
   logic                    nd;
   logic signed [IN_W-1:0]  din;
   logic                    rdy;
   logic signed [OUT_W-1:0] dout;
   logic                    ovf;

   cic_comp_fir #(
      .IN_WIDTH   (38),
      .SHIFT      (20),
      .DATA_WIDTH (18),
      .COEF_WIDTH (18),
      .OUT_WIDTH  (18)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .nd   (nd),
      .din  (din),
      .rdy  (rdy),
      .dout (dout),
      .ovf  (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [63:0] val;
      int                 due;
   } exp_t;

   int     H [11] = '{-150, 260, 410, -620, -980, 1460, 2350, -3600, -7800, 18400, 125000};
   int     hist [21];
   bit     phase;
   int     last_comp;
   logic   exp_ovf;
   exp_t   sb [$];
   int     cyc = 0;
   int     checks = 0;
   int     failures = 0;
   int     rdy_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint reduce_ref(input longint y);
`ifdef CIC_COMP_SAT_EN
      if (y > 131071) return 131071;
      if (y < -131072) return -131072;
      return y;
`else
      logic signed [17:0] w;
      w = y[17:0];
      return longint'(w);
`endif
   endfunction

   function automatic longint model_y();
      longint acc = 0;
      for (int i = 0; i < 21; i++) acc += longint'(hist[i]) * longint'(H[(i <= 10) ? i : 20 - i]);
      return reduce_ref(acc >>> 17);
   endfunction

   function automatic longint dc_gain();
      longint g = 0;
      for (int i = 0; i < 10; i++) g += 2 * longint'(H[i]);
      return g + longint'(H[10]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 21; i++) hist[i] = 0;
      phase     = 1'b0;
      last_comp = -1000;
      exp_ovf   = 1'b0;
      sb.delete();
   endtask

   task automatic model_accept(input int xv, input int edge_n);
      exp_t e;
      if (edge_n >= last_comp + 1 && edge_n <= last_comp + 11) begin
         exp_ovf = 1'b1;
      end else begin
         for (int i = 20; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = xv;
         if (phase) begin
            e.val = model_y();
            e.due = edge_n + 12;
            sb.push_back(e);
            last_comp = edge_n;
         end
         phase = ~phase;
      end
   endtask

   task automatic drive_nd(input int xv, input logic [19:0] low);
      logic signed [17:0] xs;
      xs  = xv[17:0];
      nd  = 1'b1;
      din = {xs, low};
      model_accept(xv, cyc + 1);
      @(negedge clk);
      nd  = 1'b0;
      din = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int budget = 40;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check(tag, sb.size(), 0);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      nd  = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      check("reset_rdy", rdy, 0);
      check("reset_dout", dout, 0);
      check("reset_ovf", ovf, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rdy === 1'b1) begin
         rdy_seen++;
         if (sb.size() == 0) begin
            check("rdy_without_pending_result", 1, 0);
         end else begin
            e = sb.pop_front();
            check("dout", dout, e.val);
            check("latency_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      int seen_before;
      int xv;
      rst = 1'b0;
      nd  = 1'b0;
      din = '0;
      model_reset();

      // reset held while nd toggles
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         nd  = ~nd;
         din = {18'sd1000, 20'd0};
         @(negedge clk);
         check("rst_hold_rdy", rdy, 0);
         check("rst_hold_dout", dout, 0);
         check("rst_hold_ovf", ovf, 0);
      end
      nd  = 1'b0;
      din = '0;
      rst = 1'b1;
      model_reset();

      // impulse then zeros at 12-cycle spacing
      drive_nd(1024, 20'd0);
      idle(11);
      for (int n = 0; n < 23; n++) begin
         drive_nd(0, 20'd0);
         idle(11);
      end
      drain("impulse_drain");
      check("impulse_ovf", ovf, 0);

      // DC
      apply_reset();
      for (int n = 0; n < 30; n++) begin
         drive_nd(4096, 20'd0);
         idle(11);
      end
      drain("dc_drain");
      check("dc_settle", dout, reduce_ref((4096 * dc_gain()) >>> 17));
      check("dc_ovf", ovf, 0);

      // random data, junk below the prescale point, non-computing samples closely spaced
      apply_reset();
      for (int n = 0; n < 16; n++) begin
         xv = int'($urandom_range(0, 262143)) - 131072;
         drive_nd(xv, 20'($urandom));
         idle($urandom_range(0, 3));
         xv = int'($urandom_range(0, 262143)) - 131072;
         drive_nd(xv, 20'($urandom));
         idle(11);
      end
      drain("random_drain");

      // overrun: second nd five cycles after a computing one is dropped
      apply_reset();
      drive_nd(3000, 20'd0);
      drive_nd(-2000, 20'd0);
      idle(4);
      drive_nd(50000, 20'd0);
      check("ovf_set", ovf, 1);
      check("ovf_model", ovf, exp_ovf);
      idle(6);
      drive_nd(700, 20'd0);
      drive_nd(-900, 20'd0);
      idle(11);
      drain("overrun_drain");
      check("ovf_sticky", ovf, 1);

      // saturation / wrap with near-full-scale DC
      apply_reset();
      for (int n = 0; n < 30; n++) begin
         drive_nd(131071, 20'd0);
         idle(11);
      end
      drain("sat_drain");
      check("sat_settle", dout, reduce_ref((131071 * dc_gain()) >>> 17));

      // reset at E6 of a computation: no rdy, zeroed history afterwards
      apply_reset();
      drive_nd(20000, 20'd0);
      drive_nd(-15000, 20'd0);
      idle(5);
      seen_before = rdy_seen;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      check("midmac_dout", dout, 0);
      check("midmac_rdy", rdy, 0);
      idle(15);
      check("midmac_no_rdy", rdy_seen, seen_before);
      drive_nd(500, 20'd0);
      drive_nd(-300, 20'd0);
      idle(11);
      drain("midmac_drain");
      check("midmac_ovf", ovf, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=%0d expected=0", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Droop-compensating, decimate-by-2 FIR stage directly downstream of the 5-stage CIC decimator (`cic_dec_n5`). It consumes the CIC's `rdy`/`dout` stream and rescales the 38-bit CIC word to the FIR data width. It then runs a 21-tap symmetric compensation filter on a single time-multiplexed multiplier and emits one filtered sample for every second CIC output. It uses the 12-cycle CIC output spacing as its MAC budget.

## Interface
- `IN_WIDTH`, 38: width of `din` (CIC output width).
- `SHIFT`, 20: arithmetic right shift applied to `din` before filtering (CIC gain normalisation).
- `DATA_WIDTH`, 18: internal sample width after prescale.
- `COEF_WIDTH`, 18: signed coefficient width, Q1.17.
- `OUT_WIDTH`, 18: width of `dout`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `nd`  in  1  new-data strobe, one cycle per sample (driven by CIC `rdy`).
- `din`  in  IN_WIDTH  signed sample, valid when `nd`=1.
- `rdy`  out  1  one-cycle pulse, `dout` valid.
- `dout`  out  OUT_WIDTH  signed filtered, decimated sample.
- `ovf`  out  1  sticky overrun flag.

## Operation
- Reset (`rst`=0 at a clock edge): `rdy`=0, `dout`=0, `ovf`=0, 21-entry delay line zeroed, phase=0, accumulator=0, state=IDLE.
- Prescale: x = `din[SHIFT+DATA_WIDTH-1:SHIFT]`, a pure bit-select. Upper bits are discarded.
- Accept rule: `nd` is accepted in IDLE and OUT. On acceptance, x shifts into tap 0 of the delay line and phase toggles.
- If the accepted sample arrives with phase=1 (2nd, 4th, ... after reset), the state goes to MAC. Otherwise the block stays in, or returns to, IDLE.
- `nd` in MAC: the sample is dropped, the delay line is untouched, and `ovf` is set to 1. `ovf` holds until reset.
- FSM states and transitions:
  - IDLE → MAC on a computing accept.
  - MAC lasts exactly 11 cycles, k=0..10, then goes to OUT.
  - OUT lasts 1 cycle, then goes to MAC if a computing `nd` is accepted that cycle, else IDLE.
- MAC step k<10: acc += (d[k] + d[20-k]) * h[k], where the pre-add is DATA_WIDTH+1 bits.
- MAC step k=10: acc += d[10] * h[10]. The centre tap is not doubled.
- The accumulator is cleared at MAC entry. Width is DATA_WIDTH+1+COEF_WIDTH+4 = 41 bits.
- Result: y = acc >>> 17 (arithmetic), reduced to OUT_WIDTH per Configuration.
- `dout` is registered in OUT and holds until the next result.

## Timing
- Computing `nd` accepted at edge E0.
- MAC occupies edges E1..E11.
- `rdy`=1 and the new `dout` appear after E12, for exactly one cycle.
- Latency is 12 cycles, nd-edge to rdy.
- Minimum accepted spacing after a computing sample is 12 cycles. `nd` at E12, the OUT cycle, is accepted. `nd` at E1..E11 overruns.
- Non-computing samples have no spacing constraint, provided the block is in IDLE or OUT.
- Reset asserted mid-MAC: the next edge forces the reset state. No `rdy` pulse is generated for the aborted computation.

## Configuration
- `CIC_COMP_SAT_EN` defined: y saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- `CIC_COMP_SAT_EN` undefined: y is truncated to its low OUT_WIDTH bits (two's-complement wrap).

## Structure
- Package `cic_comp_pkg` holds the following shared items:
  - `TAPS`=21 and `NUM_MAC`=11.
  - `COEF_FRAC`=17.
  - The 11 unique coefficients h[0..10] as a constant array.
  - The FSM state encoding IDLE/MAC/OUT.
- Sub-module `cic_comp_mac` holds the pre-adder, multiplier and 41-bit accumulator, with `clr`, `en`, two operands plus a coefficient in, and `acc` out.
- The top level holds the delay line, FSM, phase, `ovf` and output reduction.

## Test plan
- Reset check: drive `rst`=0 for 2 cycles while `nd` toggles → `rdy`=0, `dout`=0, `ovf`=0 throughout.
- Impulse: one sample with `din`=1024<<20, then zeros at 12-cycle spacing → each `dout` equals (1024*h[k])>>>17. Expected k sequence is 1, 3, ..., 9, then 9, 7, ..., 1, with zeros elsewhere. Each `rdy` is 12 cycles after its computing `nd`.
- DC: constant `din`=4096<<20 at 12-cycle spacing for 30 samples → `dout` settles to (4096*(2*Σh[0..9]+h[10]))>>>17.
- Overrun: computing `nd`, then another `nd` 5 cycles later → `ovf`=1 and stays 1. The dropped sample does not affect the next output, which is checked against the model.
- Saturation: `din` = (2^17-1)<<20 constant → with `CIC_COMP_SAT_EN`, `dout` = 131071 if the gain exceeds 1. Without the macro, `dout` equals the wrapped low 18 bits of the model.
- Mid-MAC reset: `rst`=0 at E6 after a computing `nd` → no `rdy` pulse, `dout`=0, next output computed from a zeroed delay line.
